// File: rtl/m_bus_ctrl_pkg.sv
// Shared definitions for the M-stage data-bus controller: address map,
// FSM state encodings and one-hot slave select codes.
package m_bus_ctrl_pkg;

    // Address map (inclusive bounds)
    localparam logic [31:0] DM_ADDR_BEGIN  = 32'h0000_0000;
    localparam logic [31:0] DM_ADDR_END    = 32'h0000_2FFF;
    localparam logic [31:0] TC0_ADDR_BEGIN = 32'h0000_7F00;
    localparam logic [31:0] TC0_ADDR_END   = 32'h0000_7F0B;
    localparam logic [31:0] TC1_ADDR_BEGIN = 32'h0000_7F10;
    localparam logic [31:0] TC1_ADDR_END   = 32'h0000_7F1B;

    // One-hot slave select, bit order {TC1, TC0, DM}
    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_DM   = 3'b001;
    localparam logic [2:0] SEL_TC0  = 3'b010;
    localparam logic [2:0] SEL_TC1  = 3'b100;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        BUS_ISSUE = 2'd1,
        BUS_DONE  = 2'd2,
        BUS_ERR   = 2'd3
    } bus_state_t;

    // Inclusive range test used by the address decoder
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/m_bus_addr_dec.sv
// Combinational address decoder: maps a byte address to a one-hot slave
// select and flags addresses outside every region. Also usable by the
// exception-check logic, so it carries no state.
import m_bus_ctrl_pkg::*;

module m_bus_addr_dec (
    input  logic [31:0] i_Addr,
    output logic [2:0]  o_sel,
    output logic        o_unmapped
);

    // Region lookup; regions never overlap so priority order is irrelevant
    always_comb begin
        // NOTE: every output gets a default before the branches so no latch is inferred.
        o_sel      = SEL_NONE;
        o_unmapped = 1'b0;
        if (in_range(i_Addr, DM_ADDR_BEGIN, DM_ADDR_END)) begin
            o_sel = SEL_DM;
        end else if (in_range(i_Addr, TC0_ADDR_BEGIN, TC0_ADDR_END)) begin
            o_sel = SEL_TC0;
        end else if (in_range(i_Addr, TC1_ADDR_BEGIN, TC1_ADDR_END)) begin
            o_sel = SEL_TC1;
        end else begin
            o_unmapped = 1'b1;
        end
    end

endmodule

// File: rtl/m_bus_ctrl.sv
// M-stage data-bus controller. Captures one CPU load/store, issues it to
// the decoded slave with a valid/ready handshake, stalls the pipeline
// until the slave answers, and reports unmapped addresses or slave
// timeouts as a bus error. Slave and result outputs are registered; only
// o_stall is combinational so the request cycle itself can freeze M.
import m_bus_ctrl_pkg::*;

module m_bus_ctrl #(
    parameter int TIMEOUT = 16,  // max cycles of valid without ready
    parameter int CNT_W   = 5    // 2**CNT_W must exceed TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_byteen,
    input  logic        i_exc,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_bus_err,
    output logic [2:0]  o_sel,
    output logic        o_s_valid,
    output logic        o_s_we,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_wdata,
    output logic [3:0]  o_s_byteen,
    input  logic        i_s_ready,
    input  logic [31:0] i_s_rdata
);

    // Last wait-counter value before the access is declared timed out
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bus_state_t      state;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]      dec_sel;
    logic            dec_unmapped;
    logic            take_req;

    m_bus_addr_dec u_addr_dec (
        .i_Addr     (i_Addr),
        .o_sel      (dec_sel),
        .o_unmapped (dec_unmapped)
    );

    // A request is accepted only when no exception or flush kills it
    assign take_req = i_req & ~i_exc & ~i_flush;

    // Freeze the pipeline from the request cycle until the slave answers
    assign o_stall = ((state == BUS_IDLE) & take_req) | (state == BUS_ISSUE);

    // Handshake FSM with wait counter, request latch and registered outputs
    always_ff @(posedge clk) begin
        // NOTE: all state here is updated with non-blocking assignments so every
        // register sees the pre-edge values of the others.
        if (reset) begin
            state      <= BUS_IDLE;
            wait_cnt   <= '0;
            o_rdata    <= '0;
            o_done     <= 1'b0;
            o_bus_err  <= 1'b0;
            o_sel      <= SEL_NONE;
            o_s_valid  <= 1'b0;
            o_s_we     <= 1'b0;
            o_s_addr   <= '0;
            o_s_wdata  <= '0;
            o_s_byteen <= '0;
        end else begin
            o_done    <= 1'b0;
            o_bus_err <= 1'b0;
            case (state)
                BUS_IDLE: begin
                    if (take_req) begin
                        if (dec_unmapped) begin
                            state     <= BUS_ERR;
                            o_done    <= 1'b1;
                            o_bus_err <= 1'b1;
                        end else begin
                            state      <= BUS_ISSUE;
                            wait_cnt   <= '0;
                            o_s_valid  <= 1'b1;
                            o_sel      <= dec_sel;
                            o_s_we     <= i_we;
                            o_s_addr   <= i_Addr;
                            o_s_wdata  <= i_wdata;
                            o_s_byteen <= i_we ? i_byteen : 4'h0;
                        end
                    end
                end
                // Flush is deliberately ignored: a started access always completes
                BUS_ISSUE: begin
                    if (i_s_ready) begin
                        if (!o_s_we) begin
                            o_rdata <= i_s_rdata;
                        end
                        state     <= BUS_DONE;
                        o_s_valid <= 1'b0;
                        o_done    <= 1'b1;
                    end else if (wait_cnt == CNT_LAST) begin
                        state     <= BUS_ERR;
                        o_s_valid <= 1'b0;
                        o_done    <= 1'b1;
                        o_bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                // Result cycle; the next request is evaluated only back in IDLE
                BUS_DONE, BUS_ERR: begin
                    state <= BUS_IDLE;
                end
                default: begin
                    state <= BUS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_bus_ctrl.sv
// Directed bench for m_bus_ctrl: a behavioural slave answers after a
// programmable delay, expected results are queued when each access is
// driven and compared when o_done appears.
module tb_m_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_we, i_exc, i_flush;
    logic [31:0] i_Addr, i_wdata;
    logic [3:0]  i_byteen;
    logic        o_stall, o_done, o_bus_err, o_s_valid, o_s_we;
    logic [31:0] o_rdata, o_s_addr, o_s_wdata;
    logic [2:0]  o_sel;
    logic [3:0]  o_s_byteen;
    logic        i_s_ready;
    logic [31:0] i_s_rdata;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [2:0]  sel;
        logic        chk_sel;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_rdata;
    int          n_check = 0;
    int          n_pass  = 0;

    always #5 clk = ~clk;

    m_bus_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_Addr     (i_Addr),
        .i_wdata    (i_wdata),
        .i_byteen   (i_byteen),
        .i_exc      (i_exc),
        .i_flush    (i_flush),
        .o_stall    (o_stall),
        .o_done     (o_done),
        .o_rdata    (o_rdata),
        .o_bus_err  (o_bus_err),
        .o_sel      (o_sel),
        .o_s_valid  (o_s_valid),
        .o_s_we     (o_s_we),
        .o_s_addr   (o_s_addr),
        .o_s_wdata  (o_s_wdata),
        .o_s_byteen (o_s_byteen),
        .i_s_ready  (i_s_ready),
        .i_s_rdata  (i_s_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every output must be zero (reset state with no request pending)
    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},  {31'd0, o_stall},   32'd0);
        check({tag, "_done"},   {31'd0, o_done},    32'd0);
        check({tag, "_err"},    {31'd0, o_bus_err}, 32'd0);
        check({tag, "_valid"},  {31'd0, o_s_valid}, 32'd0);
        check({tag, "_sel"},    {29'd0, o_sel},     32'd0);
        check({tag, "_rdata"},  o_rdata,            32'd0);
        check({tag, "_addr"},   o_s_addr,           32'd0);
        check({tag, "_wdata"},  o_s_wdata,          32'd0);
        check({tag, "_byteen"}, {28'd0, o_s_byteen}, 32'd0);
        check({tag, "_we"},     {31'd0, o_s_we},    32'd0);
    endtask

    // One complete access; entered and left just after a rising edge.
    // The slave raises ready in the (delay+1)-th valid cycle, or never if hang.
    task automatic run_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input int delay, input bit hang, input logic [31:0] rd,
                              input logic [2:0] exp_sel, input bit exp_err,
                              input int exp_valid, input int exp_stall);
        exp_t e;
        int   vcnt = 0;
        int   scnt = 0;
        int   vc   = 0;
        bit   seen = 1'b0;
        e.err     = exp_err;
        e.rdata   = (!we && !exp_err) ? rd : last_rdata;
        e.sel     = exp_sel;
        e.chk_sel = !exp_err;
        last_rdata = e.rdata;
        sb.push_back(e);
        i_req = 1'b1; i_we = we; i_Addr = addr; i_wdata = wdata; i_byteen = be;
        for (int n = 0; n < 64 && !seen; n++) begin
            #1;
            if (o_stall) scnt++;
            if (o_s_valid) begin
                vcnt++;
                if (vcnt == 1) begin
                    check({tag, "_s_addr"},   o_s_addr, addr);
                    check({tag, "_s_we"},     {31'd0, o_s_we}, {31'd0, we});
                    check({tag, "_s_wdata"},  o_s_wdata, wdata);
                    check({tag, "_s_byteen"}, {28'd0, o_s_byteen}, {28'd0, (we ? be : 4'h0)});
                    check({tag, "_s_sel"},    {29'd0, o_sel}, {29'd0, exp_sel});
                end
                i_s_ready = !hang && (vc == delay);
                i_s_rdata = rd;
                vc++;
            end else begin
                i_s_ready = 1'b0;
                i_s_rdata = 32'hBAD0_0BAD;
            end
            step();
            i_s_ready = 1'b0;
            i_s_rdata = 32'hBAD0_0BAD;
            if (o_done) begin
                seen = 1'b1;
                if (sb.size() != 0) e = sb.pop_front();
                check({tag, "_bus_err"},    {31'd0, o_bus_err}, {31'd0, e.err});
                check({tag, "_rdata"},      o_rdata, e.rdata);
                check({tag, "_stall_done"}, {31'd0, o_stall}, 32'd0);
                if (e.chk_sel) check({tag, "_sel_done"}, {29'd0, o_sel}, {29'd0, e.sel});
            end
        end
        check({tag, "_completed"}, {31'd0, seen}, 32'd1);
        check({tag, "_valid_cycles"}, vcnt, exp_valid);
        check({tag, "_stall_cycles"}, scnt, exp_stall);
        // i_req still high through the DONE/ERR cycle: no re-issue may follow
        step();
        i_req = 1'b0;
        check({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
        check({tag, "_no_reissue"}, {31'd0, o_s_valid}, 32'd0);
    endtask

    // Killed request: nothing may issue or stall for a few cycles
    task automatic run_killed(input string tag, input bit exc, input bit flush);
        i_req = 1'b1; i_we = 1'b0; i_Addr = 32'h0000_0100; i_exc = exc; i_flush = flush;
        for (int n = 0; n < 3; n++) begin
            #1;
            check({tag, "_stall"}, {31'd0, o_stall},   32'd0);
            check({tag, "_valid"}, {31'd0, o_s_valid}, 32'd0);
            check({tag, "_done"},  {31'd0, o_done},    32'd0);
            step();
        end
        i_req = 1'b0; i_exc = 1'b0; i_flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; i_we = 1'b0; i_Addr = '0; i_wdata = '0; i_byteen = '0;
        i_exc = 1'b0; i_flush = 1'b0; i_s_ready = 1'b0; i_s_rdata = 32'hBAD0_0BAD;
        last_rdata = '0;
        step();
        step();
        reset = 1'b0;
        step();
        check_all_zero("reset");

        // DM load, ready in the 2nd valid cycle
        run_access("dm_load", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1, 1'b0, 32'hDEAD_BEEF,
                   3'b001, 1'b0, 2, 3);
        // TC0 store, ready in the same cycle; rdata must not move
        run_access("tc0_store", 1'b1, 32'h0000_7F04, 32'h0000_0005, 4'hF, 0, 1'b0, 32'hFFFF_FFFF,
                   3'b010, 1'b0, 1, 2);
        // Unmapped load
        run_access("unmapped", 1'b0, 32'h0000_4000, 32'h0, 4'h0, 0, 1'b0, 32'h1111_1111,
                   3'b000, 1'b1, 0, 1);
        // Just past the DM region
        run_access("dm_edge_out", 1'b0, 32'h0000_3000, 32'h0, 4'h0, 0, 1'b0, 32'h2222_2222,
                   3'b000, 1'b1, 0, 1);
        // Last DM word
        run_access("dm_edge_in", 1'b0, 32'h0000_2FFC, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_CAFE,
                   3'b001, 1'b0, 1, 2);
        // TC1 load, partial byte enables forced to 0 on a load
        run_access("tc1_load", 1'b0, 32'h0000_7F18, 32'h0, 4'h3, 3, 1'b0, 32'h1234_5678,
                   3'b100, 1'b0, 4, 5);
        // Just past TC1
        run_access("tc1_edge_out", 1'b0, 32'h0000_7F1C, 32'h0, 4'h0, 0, 1'b0, 32'h3333_3333,
                   3'b000, 1'b1, 0, 1);
        // DM store with partial byte enables
        run_access("dm_store", 1'b1, 32'h0000_0200, 32'hA5A5_0000, 4'hC, 2, 1'b0, 32'h4444_4444,
                   3'b001, 1'b0, 3, 4);
        // Timeout: slave never answers
        run_access("timeout", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 1'b1, 32'h5555_5555,
                   3'b001, 1'b1, 16, 17);

        run_killed("exc", 1'b1, 1'b0);
        run_killed("flush", 1'b0, 1'b1);

        // Reset during the 2nd ISSUE cycle abandons the access
        i_req = 1'b1; i_we = 1'b0; i_Addr = 32'h0000_0040; i_byteen = 4'h0;
        step();
        check("rst_issue1_valid", {31'd0, o_s_valid}, 32'd1);
        step();
        check("rst_issue2_valid", {31'd0, o_s_valid}, 32'd1);
        reset = 1'b1;
        i_req = 1'b0;
        step();
        reset = 1'b0;
        last_rdata = '0;
        check_all_zero("mid_rst");
        run_access("post_rst", 1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D,
                   3'b001, 1'b0, 1, 2);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
